h_to_l_tx: RTL and testbench
============================

# h_to_l_tx

Source-side transmitter for moving single-cycle event pulses from a fast clock domain into a slower destination domain. Events cannot be sent as raw pulses here, because the destination may miss them. Each event is sent as one transition on a toggle request line, and the block waits for the destination to echo that toggle back before sending the next one. Events that arrive during a handshake are counted and drained in order, so none are lost until the counter saturates.

## Interface
Parameters:
- CNT_W, default 4: width of the pending-event counter; saturates at 2^CNT_W-1.
- SYNC_STAGES, default 2: flop stages on the incoming ack toggle; legal range 2..4.

Ports:
- clk_s, input, 1: source clock. This is the only clock in the block.
- rst_s, input, 1: reset, synchronous, active-high.
- event_s, input, 1: event strobe in the clk_s domain. Each cycle it is high counts as one event; back-to-back cycles are legal.
- ack_tgl_a, input, 1: ack toggle from the destination. It is asynchronous to clk_s and is synchronized internally.
- req_tgl, output, 1: request toggle to the destination. Driven straight from a flop with no logic after it; each transition is one event.
- pending, output, CNT_W: number of events accepted but not yet launched.
- busy, output, 1: high while a launched request is still waiting for its ack.
- overflow, output, 1: sticky flag, set when an event is dropped because the counter is saturated.

## Operation
- **ack_sync:** ack_tgl_a passed through SYNC_STAGES flops.
- **Two states:**
  - IDLE (busy=0).
  - WAIT_ACK (busy=1).
- **Launch condition:** state==IDLE && pending!=0 && ack_sync==req_tgl. On a launch:
  - req_tgl inverts;
  - state goes to WAIT_ACK;
  - pending decrements by 1.
- **WAIT_ACK → IDLE:** when ack_sync==req_tgl. There is no launch on the same edge; the earliest next launch is on the following edge.
- **pending update each edge:** next = pending + event_s − launch.
  - Event and launch on the same edge: pending is unchanged.
  - pending==max, event_s=1, no launch: pending holds at max and overflow is set. The event is lost.
  - pending==max, event_s=1, with launch: pending stays at max and overflow is not set.
- **overflow:** stays set until rst_s.
- **Stale ack:** while in IDLE, ack_sync!=req_tgl blocks launches. This covers the case where the destination was not reset together with the source. No event is sent until the two sides match again.
- **Reset values:** when rst_s is sampled high, every flop is cleared, including the synchronizer stages:
  - state=IDLE;
  - req_tgl=0, pending=0, busy=0, overflow=0.
- **Reset during WAIT_ACK:** the outstanding request and all pending events are discarded.

## Timing
- **Event to request:** event_s high in cycle 0 is captured at edge 1 (pending=1). The launch happens at edge 2 (req_tgl flips, pending=0, busy=1).
- **Ack return:** a transition on ack_tgl_a is seen on ack_sync SYNC_STAGES edges later. WAIT_ACK exits on the edge after ack_sync matches.
- **Throughput:** at most one event per handshake round trip, which is at least SYNC_STAGES+2 clk_s cycles plus the destination's latency.
- **Outputs:** req_tgl, pending, busy and overflow are all registered.
- **Synchronizer constraint:** ack_tgl_a must not feed any logic other than the first synchronizer flop.

## Structure
- **Package h_to_l_pkg:**
  - state enum (IDLE, WAIT_ACK);
  - default values for CNT_W and SYNC_STAGES.
- **Sub-module sync_bit_sr:** single-bit synchronizer, depth parameter STAGES, synchronous active-high reset to 0. It is instantiated once for ack_tgl_a.
- **Top level:** the FSM, the saturating counter and the req_tgl flop.

## Test plan
1. **Single event:** one event_s pulse, with an ack model that echoes req after 3 cycles.
   - Expected: req_tgl 0→1 two edges after the pulse, pending 1→0, busy high until ack_sync matches, then IDLE.
2. **Burst:** 3 back-to-back events with the echo model.
   - Expected: pending peaks at 2; exactly 3 req_tgl transitions, each separated by a completed handshake; pending ends at 0; overflow stays 0.
3. **Saturation:** CNT_W=2, ack held constant, 6 events.
   - Expected: the first event launches, pending reaches 3 and holds, overflow becomes 1 and stays 1.
4. **Simultaneous event and launch:** event_s high on the launch edge with pending=1.
   - Expected: pending stays 1 and req_tgl flips.
5. **Reset mid-handshake:** rst_s high for 1 cycle during WAIT_ACK with pending=2.
   - Expected: all outputs return to 0 and state is IDLE on the next edge.
6. **Stale ack:** after reset, hold ack_tgl_a=1 and send 1 event.
   - Expected: pending=1 with no launch. When ack_tgl_a is driven to 0, the launch happens SYNC_STAGES+1 edges later.

Source files
------------

// File: rtl/h_to_l_pkg.sv
// Shared types and defaults for the fast-to-slow toggle-handshake transmitter.
package h_to_l_pkg;

    localparam int unsigned CNT_W_DEFAULT       = 4;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_e;

endpackage

// File: rtl/sync_bit_sr.sv
// Single-bit multi-flop synchronizer with synchronous active-high reset to 0.
module sync_bit_sr #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_s,
    input  logic rst_s,
    input  logic din_a,
    output logic dout
);

    logic [STAGES-1:0] sync_q;

    // din_a is asynchronous: it may only reach the first flop of this chain
    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din_a};
        end
    end

    assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/h_to_l_tx.sv
// Source-side transmitter: buffers event pulses in a saturating counter and
// launches them one at a time as transitions on a toggle request line.
module h_to_l_tx
    import h_to_l_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk_s,
    input  logic             rst_s,
    input  logic             event_s,
    input  logic             ack_tgl_a,
    output logic             req_tgl,
    output logic [CNT_W-1:0] pending,
    output logic             busy,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             ovf_q, ovf_d;
    logic             ack_sync;
    logic             launch;

    sync_bit_sr #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk_s (clk_s),
        .rst_s (rst_s),
        .din_a (ack_tgl_a),
        .dout  (ack_sync)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        pend_d  = pend_q;
        ovf_d   = ovf_q;

        // A mismatched ack in IDLE (stale destination) also blocks launching
        launch = (state_q == IDLE) && (pend_q != '0) && (ack_sync == req_q);

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = WAIT_ACK;
                    req_d   = ~req_q;
                end
            end
            WAIT_ACK: begin
                if (ack_sync == req_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // At saturation an event is only lost when no launch frees a slot
        if (event_s && !launch) begin
            if (pend_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + CNT_ONE;
            end
        end else if (!event_s && launch) begin
            pend_d = pend_q - CNT_ONE;
        end

        busy_d = (state_d == WAIT_ACK);
    end

    always_ff @(posedge clk_s) begin
        if (rst_s) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            pend_q  <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign req_tgl  = req_q;
    assign pending  = pend_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_h_to_l_tx.sv
// Directed bench for h_to_l_tx with a 3-cycle ack echo model and manual ack.
module tb_h_to_l_tx;

    localparam int unsigned CNT_W       = 2;
    localparam int unsigned SYNC_STAGES = 2;

    logic             clk_s = 1'b0;
    logic             rst_s;
    logic             event_s;
    logic             ack_tgl_a;
    logic             req_tgl;
    logic [CNT_W-1:0] pending;
    logic             busy;
    logic             overflow;

    logic       echo_en;
    logic       ack_man;
    logic [2:0] echo_pipe;

    int n_checks = 0;
    int n_errors = 0;

    h_to_l_tx #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk_s     (clk_s),
        .rst_s     (rst_s),
        .event_s   (event_s),
        .ack_tgl_a (ack_tgl_a),
        .req_tgl   (req_tgl),
        .pending   (pending),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk_s = ~clk_s;

    // Destination model: echoes req_tgl back three cycles later
    always @(negedge clk_s) echo_pipe <= {echo_pipe[1:0], req_tgl};
    assign ack_tgl_a = echo_en ? echo_pipe[2] : ack_man;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_s);
        #1;
    endtask

    task automatic reset_dut();
        rst_s   = 1'b1;
        event_s = 1'b0;
        tick();
        rst_s   = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int max_cyc);
        int n = 0;
        while (!(busy === 1'b0 && pending === '0) && n < max_cyc) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(n < max_cyc), 32'd1);
    endtask

    int exp_pend[6] = '{1, 1, 2, 3, 3, 3};
    int exp_ovf[6]  = '{0, 0, 0, 0, 1, 1};

    initial begin
        int n_flips;
        int last_flip;
        int gap_bad;
        int peak;
        logic prev_req;

        echo_pipe = 3'b000;
        echo_en   = 1'b1;
        ack_man   = 1'b0;
        event_s   = 1'b0;
        rst_s     = 1'b0;
        tick();
        reset_dut();
        check_eq("rst_req", 32'(req_tgl), 0);
        check_eq("rst_pend", 32'(pending), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_ovf", 32'(overflow), 0);

        // Single event: capture, launch two edges after the pulse, full handshake
        tick();
        event_s = 1'b1;
        tick();
        event_s = 1'b0;
        check_eq("t1_pend_cap", 32'(pending), 1);
        check_eq("t1_req_cap", 32'(req_tgl), 0);
        tick();
        check_eq("t1_req_launch", 32'(req_tgl), 1);
        check_eq("t1_pend_launch", 32'(pending), 0);
        check_eq("t1_busy_launch", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t1_busy_wait", 32'(busy), 1);
        end
        tick();
        check_eq("t1_busy_done", 32'(busy), 0);

        // Burst of three: peak 2, three launches six edges apart
        n_flips   = 0;
        last_flip = -1;
        gap_bad   = 0;
        peak      = 0;
        prev_req  = req_tgl;
        for (int i = 0; i < 40; i++) begin
            event_s = (i < 3);
            tick();
            if (32'(pending) > peak) peak = 32'(pending);
            if (req_tgl !== prev_req) begin
                if (last_flip >= 0 && i - last_flip != 6) gap_bad++;
                last_flip = i;
                n_flips++;
                prev_req = req_tgl;
            end
        end
        event_s = 1'b0;
        check_eq("t2_peak", 32'(peak), 2);
        check_eq("t2_flips", 32'(n_flips), 3);
        check_eq("t2_gap", 32'(gap_bad), 0);
        check_eq("t2_pend_end", 32'(pending), 0);
        check_eq("t2_busy_end", 32'(busy), 0);
        check_eq("t2_ovf", 32'(overflow), 0);
        check_eq("t2_req_end", 32'(req_tgl), 0);

        // Event coincident with launch keeps pending at 1
        event_s = 1'b1;
        tick();
        check_eq("t4_pend_cap", 32'(pending), 1);
        tick();
        event_s = 1'b0;
        check_eq("t4_pend_same", 32'(pending), 1);
        check_eq("t4_req_flip", 32'(req_tgl), 1);
        wait_drain("t4_drain_timeout", 40);
        check_eq("t4_req_end", 32'(req_tgl), 0);

        // Reset mid-handshake with pending=2
        for (int i = 0; i < 3; i++) begin
            event_s = 1'b1;
            tick();
        end
        event_s = 1'b0;
        check_eq("t5_pend_pre", 32'(pending), 2);
        check_eq("t5_busy_pre", 32'(busy), 1);
        reset_dut();
        check_eq("t5_req", 32'(req_tgl), 0);
        check_eq("t5_pend", 32'(pending), 0);
        check_eq("t5_busy", 32'(busy), 0);
        check_eq("t5_ovf", 32'(overflow), 0);

        // Stale ack blocks launching until it matches req_tgl again
        echo_en = 1'b0;
        ack_man = 1'b1;
        reset_dut();
        repeat (3) tick();
        event_s = 1'b1;
        tick();
        event_s = 1'b0;
        repeat (3) tick();
        check_eq("t6_pend_block", 32'(pending), 1);
        check_eq("t6_req_block", 32'(req_tgl), 0);
        check_eq("t6_busy_block", 32'(busy), 0);
        ack_man = 1'b0;
        tick();
        tick();
        check_eq("t6_req_early", 32'(req_tgl), 0);
        tick();
        check_eq("t6_req_launch", 32'(req_tgl), 1);
        check_eq("t6_pend_launch", 32'(pending), 0);

        // Saturated counter with a launch on the same edge: no overflow
        ack_man = 1'b1;
        reset_dut();
        repeat (3) tick();
        for (int i = 0; i < 3; i++) begin
            event_s = 1'b1;
            tick();
        end
        event_s = 1'b0;
        check_eq("t3b_pend_max", 32'(pending), 3);
        ack_man = 1'b0;
        tick();
        tick();
        event_s = 1'b1;
        tick();
        event_s = 1'b0;
        check_eq("t3b_pend_hold", 32'(pending), 3);
        check_eq("t3b_req", 32'(req_tgl), 1);
        check_eq("t3b_ovf", 32'(overflow), 0);

        // Saturation with ack held constant: six events
        ack_man = 1'b0;
        reset_dut();
        tick();
        for (int i = 0; i < 6; i++) begin
            event_s = 1'b1;
            tick();
            check_eq("t3_pend", 32'(pending), 32'(exp_pend[i]));
            check_eq("t3_ovf", 32'(overflow), 32'(exp_ovf[i]));
        end
        event_s = 1'b0;
        repeat (5) tick();
        check_eq("t3_pend_hold", 32'(pending), 3);
        check_eq("t3_ovf_sticky", 32'(overflow), 1);
        check_eq("t3_busy", 32'(busy), 1);
        check_eq("t3_req", 32'(req_tgl), 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
